// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the execute stage. It registers the decoded operands and control,
// forwards results from the Memory and Writeback stages, and drives the ALU operands.
module id_ex_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic [WIDTH-1:0]    RD1D,
  input  logic [WIDTH-1:0]    RD2D,
  input  logic [WIDTH-1:0]    SignImmD,
  input  logic [REG_ADDR-1:0] RsD,
  input  logic [REG_ADDR-1:0] RtD,
  input  logic [REG_ADDR-1:0] RdD,
  input  logic [2:0]          ALUControlD,
  input  logic                ALUSrcD,
  input  logic                RegDstD,
  input  logic                RegWriteD,
  input  logic                MemWriteD,
  input  logic                MemtoRegD,
  input  logic [WIDTH-1:0]    ALUOutM,
  input  logic [REG_ADDR-1:0] WriteRegM,
  input  logic                RegWriteM,
  input  logic [WIDTH-1:0]    ResultW,
  input  logic [REG_ADDR-1:0] WriteRegW,
  input  logic                RegWriteW,
  output logic [WIDTH-1:0]    SrcAE,
  output logic [WIDTH-1:0]    SrcBE,
  output logic [2:0]          ALUControlE,
  output logic [WIDTH-1:0]    WriteDataE,
  output logic [REG_ADDR-1:0] WriteRegE,
  output logic [REG_ADDR-1:0] RsE,
  output logic [REG_ADDR-1:0] RtE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                MemtoRegE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE
);

  logic [WIDTH-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_ADDR-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [2:0]          aluctl_q, aluctl_d;
  logic                alusrc_q, alusrc_d, regdst_q, regdst_d;
  logic                regwr_q, regwr_d, memwr_q, memwr_d, memtoreg_q, memtoreg_d;

  // Memory stage takes priority over Writeback; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR-1:0] src);
    if (RegWriteM && (WriteRegM != '0) && (WriteRegM == src))
      return 2'b10;
    else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] reg_val);
    case (sel)
      2'b10:   return ALUOutM;
      2'b01:   return ResultW;
      default: return reg_val;
    endcase
  endfunction

  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    aluctl_d   = aluctl_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    regwr_d    = regwr_q;
    memwr_d    = memwr_q;
    memtoreg_d = memtoreg_q;
    if (FlushE) begin
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      aluctl_d   = '0;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      regwr_d    = 1'b0;
      memwr_d    = 1'b0;
      memtoreg_d = 1'b0;
    end else if (!StallE) begin
      rd1_d      = RD1D;
      rd2_d      = RD2D;
      imm_d      = SignImmD;
      rs_d       = RsD;
      rt_d       = RtD;
      rd_d       = RdD;
      aluctl_d   = ALUControlD;
      alusrc_d   = ALUSrcD;
      regdst_d   = RegDstD;
      regwr_d    = RegWriteD;
      memwr_d    = MemWriteD;
      memtoreg_d = MemtoRegD;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      aluctl_q   <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      regwr_q    <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      aluctl_q   <= aluctl_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      regwr_q    <= regwr_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  // Execute-side combinational outputs: forwarding, operand select and destination.
  always_comb begin
    ForwardAE   = fwd_sel(rs_q);
    ForwardBE   = fwd_sel(rt_q);
    SrcAE       = fwd_mux(ForwardAE, rd1_q);
    WriteDataE  = fwd_mux(ForwardBE, rd2_q);
    SrcBE       = alusrc_q ? imm_q : WriteDataE;
    WriteRegE   = regdst_q ? rd_q : rt_q;
    ALUControlE = aluctl_q;
    RegWriteE   = regwr_q;
    MemWriteE   = memwr_q;
    MemtoRegE   = memtoreg_q;
    RsE         = rs_q;
    RtE         = rt_q;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the execute-stage ALU. It registers the decoded operands and control fields from Decode every clock, with stall and flush support. Combinationally, it resolves RAW hazards by forwarding from the Memory and Writeback stages. It drives SrcAE, SrcBE and ALUControlE directly into the ALU, and passes the remaining execute-stage control and data fields downstream to the EX/MEM register.

## Interface
- WIDTH, 32, datapath width
- REG_ADDR, 5, register-index width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- StallE  in  1  hold the current register contents
- FlushE  in  1  load a bubble (all fields zero)
- RD1D, RD2D  in  WIDTH  register-file read data
- SignImmD  in  WIDTH  sign-extended immediate
- RsD, RtD, RdD  in  REG_ADDR  register indices
- ALUControlD  in  3  ALU opcode (000 and, 001 or, 010 add, 100 sub, 101 mul, 110 slt)
- ALUSrcD, RegDstD, RegWriteD, MemWriteD, MemtoRegD  in  1 each  decoded control
- ALUOutM  in  WIDTH  Memory-stage ALU result
- WriteRegM  in  REG_ADDR  Memory-stage destination register
- RegWriteM  in  1  Memory-stage write enable
- ResultW  in  WIDTH  Writeback-stage result
- WriteRegW  in  REG_ADDR  Writeback-stage destination register
- RegWriteW  in  1  Writeback-stage write enable
- SrcAE, SrcBE  out  WIDTH  ALU operands
- ALUControlE  out  3  ALU opcode
- WriteDataE  out  WIDTH  forwarded Rt value, used for stores
- WriteRegE  out  REG_ADDR  destination register
- RsE, RtE  out  REG_ADDR  registered source indices, sent to the hazard unit
- RegWriteE, MemWriteE, MemtoRegE  out  1  control passed downstream
- ForwardAE, ForwardBE  out  2  forwarding select (debug/hazard visibility)

## Operation
- **Registered fields:** RD1, RD2, SignImm, Rs, Rt, Rd, ALUControl, ALUSrc, RegDst, RegWrite, MemWrite, MemtoReg. Reset value of every registered field is 0.
- **Register update, per rising edge, in priority order:**
  - RST: all fields 0.
  - FlushE: all fields 0, regardless of StallE.
  - StallE: hold.
  - Otherwise: load the D inputs.
- **Forwarding select (combinational on registered Rs/Rt):**
  - ForwardAE = 10 when RegWriteM, WriteRegM != 0 and WriteRegM == RsE.
  - Else ForwardAE = 01 when RegWriteW, WriteRegW != 0 and WriteRegW == RsE.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rules with RtE.
  - Memory stage wins over Writeback.
  - Register 0 is never forwarded.
- **Operand muxes:**
  - SrcAE = {00: RD1E, 01: ResultW, 10: ALUOutM}.
  - WriteDataE = the same mux applied to RD2E.
  - SrcBE = ALUSrcE ? SignImmE : WriteDataE.
  - ForwardAE/ForwardBE code 11 is never generated; if forced, the mux selects RD1E/RD2E.
- **Destination and pass-through:**
  - WriteRegE = RegDstE ? RdE : RtE.
  - ALUControlE, RegWriteE, MemWriteE, MemtoRegE, RsE, RtE come straight from the register.
- **Bubble:** an all-zero register gives ALUControlE=000 (and), RegWriteE=0, MemWriteE=0. A bubble commits nothing.
- **Outputs after reset:** SrcAE=0, SrcBE=0, WriteDataE=0, WriteRegE=0, ForwardAE=ForwardBE=00, all control outputs 0. This holds provided RegWriteM/RegWriteW are 0 or their WriteReg is 0.

## Timing
- **Latency:** 1 cycle from D inputs to E outputs.
- **Forwarding path:** purely combinational, same cycle. ALUOutM and ResultW changes appear on SrcAE/SrcBE/WriteDataE without a clock.
- **Reset:**
  - RST assertion clears the outputs immediately (asynchronous), mid-cycle included.
  - Deassertion takes effect at the next rising edge.
  - An instruction in flight at reset is lost and is not replayed.
- **Stall:** StallE held N cycles keeps E outputs constant except the forwarded operands, which track M/W changes.
- **Flush and stall together:** FlushE and StallE asserted in the same cycle produce a bubble.
- **No handshake:** no valid/ready signals; the stage advances every unstalled cycle.

## Test plan
- **Reset:** set D inputs to RD1D=0x11, ALUControlD=010, RegWriteD=1; assert RST asynchronously mid-cycle -> all outputs 0 immediately. Release RST -> after the next edge, SrcAE=0x11, ALUControlE=010, RegWriteE=1.
- **Immediate select:** load RD1D=5, SignImmD=0xFFFFFFFC, ALUSrcD=1, RegDstD=0, RtD=8 -> next cycle SrcAE=5, SrcBE=0xFFFFFFFC, WriteRegE=8.
- **Forwarding priority:** RsE=RtE=3, RegWriteM=1, WriteRegM=3, ALUOutM=0xAA, RegWriteW=1, WriteRegW=3, ResultW=0xBB, ALUSrcE=0 -> ForwardAE=ForwardBE=10, SrcAE=SrcBE=WriteDataE=0xAA. Drop RegWriteM -> 01 and 0xBB, same cycle.
- **Register 0:** RsE=0, WriteRegM=0, RegWriteM=1, ALUOutM=0x55 -> ForwardAE=00, SrcAE=RD1E.
- **Stall then flush:** load an instruction (RegWriteD=1, RdD=7, RegDstD=1).
  - StallE=1 for 3 cycles with changing D inputs -> WriteRegE=7 and RegWriteE=1 held throughout.
  - StallE=1 together with FlushE=1 -> next edge: RegWriteE=0, MemWriteE=0, WriteRegE=0.
- **Store data:** MemWriteD=1, ALUSrcD=1, RtD=4, WriteRegW=4, RegWriteW=1, ResultW=0x1234 -> WriteDataE=0x1234, SrcBE=SignImmE.
